rf_scan_reader: RTL and testbench

- Debug-side reader of the CPU register file.
- When debug mode is on (sw_i[1]=1, the same switch that blocks RF writes), it walks the register file's read port from x0 to x(NUM_REGS-1).
- Each captured word is presented to the display path using a valid/ready handshake.
- Each register is held for a programmable dwell before the scan advances; the scan wraps continuously.

---
 rtl/rf_scan_reader.sv | 126 ++++++++++++
 tb/tb_rf_scan_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scan_reader.sv
// Debug-mode scanner that walks the register file read port and hands each
// word to the display path over valid/ready, dwelling between registers.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | scan disabled, outputs held
// ADDR     | rf_a driven with idx, rf_rd captured at the exiting edge
// WAIT_ACK | disp_valid high, waiting for disp_ready
// HOLD     | dwell down-counter running, advances idx at terminal count
module rf_scan_reader #(
    parameter int NUM_REGS    = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_i,
    output logic [4:0]  rf_a,
    input  logic [31:0] rf_rd,
    output logic [31:0] disp_data,
    output logic [4:0]  disp_idx,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic        scan_done
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]       LAST_IDX = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADDR     = 2'd1,
        WAIT_ACK = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       idx;
    logic [CNT_W-1:0] cnt;

    logic scan_en;
    logic freeze;
    logic unused_sw;

    logic capture;
    logic ack;
    logic leave;
    logic hold_run;
    logic advance;
    logic cnt_dec;
    logic wrap;

    assign scan_en   = sw_i[1];
    assign freeze    = sw_i[0];
    assign unused_sw = ^sw_i[15:2];
    assign rf_a      = idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (scan_en) state_nxt = ADDR;
            end
            ADDR: begin
                state_nxt = scan_en ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                if (!scan_en)       state_nxt = IDLE;
                else if (disp_ready) state_nxt = HOLD;
            end
            HOLD: begin
                if (!scan_en)                   state_nxt = IDLE;
                else if (!freeze && cnt == '0) state_nxt = ADDR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dropping scan_en takes priority over capture, handshake and advance.
    always_comb begin
        capture  = (state == ADDR) && scan_en;
        ack      = (state == WAIT_ACK) && scan_en && disp_ready;
        leave    = (state != IDLE) && !scan_en;
        hold_run = (state == HOLD) && scan_en && !freeze;
        advance  = hold_run && (cnt == '0);
        cnt_dec  = hold_run && (cnt != '0);
        wrap     = advance && (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= '0;
            cnt        <= '0;
            disp_data  <= '0;
            disp_idx   <= '0;
            disp_valid <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= wrap;

            if (capture) begin
                disp_data  <= rf_rd;
                disp_idx   <= idx;
                disp_valid <= 1'b1;
            end else if (ack || leave) begin
                disp_valid <= 1'b0;
            end

            if (ack)          cnt <= CNT_LOAD;
            else if (leave)   cnt <= '0;
            else if (cnt_dec) cnt <= cnt - 1'b1;

            if (advance) idx <= wrap ? 5'd0 : idx + 5'd1;
        end
    end

endmodule

// File: tb/tb_rf_scan_reader.sv
// Bench for rf_scan_reader: cycle-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_scan_reader;

    localparam int NUM_REGS    = 8;
    localparam int HOLD_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_i;
    logic [4:0]  rf_a;
    logic [31:0] rf_rd;
    logic [31:0] disp_data;
    logic [4:0]  disp_idx;
    logic        disp_valid;
    logic        disp_ready;
    logic        scan_done;

    logic [31:0] rf [0:31];

    int n_pass  = 0;
    int n_total = 0;

    rf_scan_reader #(
        .NUM_REGS   (NUM_REGS),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_i      (sw_i),
        .rf_a      (rf_a),
        .rf_rd     (rf_rd),
        .disp_data (disp_data),
        .disp_idx  (disp_idx),
        .disp_valid(disp_valid),
        .disp_ready(disp_ready),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    assign rf_rd = rf[rf_a];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: m_wait counts qualifying edges until the next capture; the last
    // of those edges is the address edge, which a freeze cannot pause.
    bit          m_live   = 1'b0;
    bit          m_active = 1'b0;
    bit          m_valid  = 1'b0;
    bit          m_done   = 1'b0;
    int          m_wait   = 0;
    int          m_idx    = 0;
    int          m_didx   = 0;
    logic [31:0] m_data   = '0;

    always @(posedge clk) begin : model
        int          w;
        int          ix;
        int          di;
        bit          v;
        bit          act;
        bit          dn;
        logic [31:0] d;
        w   = m_wait;
        ix  = m_idx;
        di  = m_didx;
        v   = m_valid;
        act = m_active;
        d   = m_data;
        dn  = 1'b0;
        if (rst !== 1'b1) begin
            w = 0; ix = 0; di = 0; v = 1'b0; act = 1'b0; d = '0;
        end else if (!sw_i[1]) begin
            if (act) begin
                act = 1'b0; v = 1'b0; w = 0;
            end
        end else if (!act) begin
            act = 1'b1; w = 1;
        end else if (v) begin
            if (disp_ready) begin
                v = 1'b0; w = HOLD_CYCLES + 1;
            end
        end else if (w == 1) begin
            d = rf[ix]; di = ix; v = 1'b1; w = 0;
        end else if (!sw_i[0]) begin
            w = w - 1;
            if (w == 1) begin
                dn = (ix == NUM_REGS - 1);
                ix = dn ? 0 : ix + 1;
            end
        end
        m_wait   <= w;
        m_idx    <= ix;
        m_didx   <= di;
        m_valid  <= v;
        m_active <= act;
        m_data   <= d;
        m_done   <= dn;
        m_live   <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_rf_a",       32'(rf_a),       32'(m_idx));
            check("model_disp_valid", 32'(disp_valid), 32'(m_valid));
            check("model_disp_idx",   32'(disp_idx),   32'(m_didx));
            check("model_disp_data",  disp_data,       m_data);
            check("model_scan_done",  32'(scan_done),  32'(m_done));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_word(input int target);
        int n;
        n = 0;
        while (!(disp_valid === 1'b1 && disp_idx == 5'(target)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_word_timeout", 32'(n), (n < 100) ? 32'(n) : 32'd0);
    endtask

    task automatic check_word(input string name, input int exp_idx, input logic [31:0] exp_data);
        check({name, "_valid"}, 32'(disp_valid), 32'd1);
        check({name, "_idx"},   32'(disp_idx),   32'(exp_idx));
        check({name, "_data"},  disp_data,       exp_data);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rf_a"},  32'(rf_a),       32'd0);
        check({name, "_data"},  disp_data,       32'd0);
        check({name, "_idx"},   32'(disp_idx),   32'd0);
        check({name, "_valid"}, 32'(disp_valid), 32'd0);
        check({name, "_done"},  32'(scan_done),  32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int pulses;
        for (int i = 0; i < 32; i++) rf[i] = (i < NUM_REGS) ? 32'(i * 32'h11) : 32'd0;
        rst        = 1'b0;
        sw_i       = 16'h0002;
        disp_ready = 1'b1;

        // reset held for three edges
        repeat (3) begin
            tick(1);
            check_all_zero("reset_hold");
        end

        rst = 1'b1;
        tick(1);
        check("enable_latency_early", 32'(disp_valid), 32'd0);
        tick(1);
        check_word("first_word", 0, 32'h0);

        tick(HOLD_CYCLES + 1);
        check("spacing_gap1", 32'(disp_valid), 32'd0);
        tick(1);
        check_word("second_word", 1, 32'h11);
        tick(HOLD_CYCLES + 1);
        check("spacing_gap2", 32'(disp_valid), 32'd0);
        tick(1);
        check_word("third_word", 2, 32'h22);

        // backpressure on idx3
        tick(1);
        disp_ready = 1'b0;
        wait_word(3);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_word("backpressure", 3, 32'h33);
        end
        disp_ready = 1'b1;
        tick(1);
        check("backpressure_release", 32'(disp_valid), 32'd0);

        // wrap and scan_done over three full scans
        wait_word(7);
        check("wrap_last_data", disp_data, 32'h77);
        wait_word(0);
        check("wrap_first_data", disp_data, 32'h0);
        pulses = 0;
        for (int i = 0; i < 3 * NUM_REGS * (HOLD_CYCLES + 2); i++) begin
            tick(1);
            if (scan_done === 1'b1) begin
                pulses++;
                check("wrap_pulse_rf_a", 32'(rf_a), 32'd0);
            end
        end
        check("wrap_pulse_count", 32'(pulses), 32'd3);

        // freeze after one dwell cycle at idx4
        wait_word(4);
        check("freeze_word_data", disp_data, 32'h44);
        tick(1);
        tick(1);
        sw_i = 16'h0003;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("freeze_valid", 32'(disp_valid), 32'd0);
            check("freeze_rf_a",  32'(rf_a),       32'd4);
        end
        sw_i       = 16'h0002;
        disp_ready = 1'b0;
        tick(HOLD_CYCLES - 1);
        check("freeze_resume_early", 32'(disp_valid), 32'd0);
        tick(1);
        check_word("freeze_resume", 5, 32'h55);

        // drop debug mode while waiting for the handshake
        sw_i = 16'h0000;
        tick(1);
        check("disable_valid", 32'(disp_valid), 32'd0);
        check("disable_idx",   32'(disp_idx),   32'd5);
        check("disable_data",  disp_data,       32'h55);
        rf[5] = 32'h0000ABCD;
        tick(3);
        check("disable_rf_a", 32'(rf_a), 32'd5);
        sw_i = 16'h0002;
        tick(1);
        check("reenable_early", 32'(disp_valid), 32'd0);
        tick(1);
        check_word("reenable_word", 5, 32'h0000ABCD);

        // reset in the middle of HOLD at idx6
        disp_ready = 1'b1;
        wait_word(6);
        check("pre_reset_data", disp_data, 32'h66);
        tick(1);
        tick(1);
        rst = 1'b0;
        tick(1);
        check_all_zero("mid_reset");
        rst = 1'b1;
        tick(1);
        check("restart_early", 32'(disp_valid), 32'd0);
        tick(1);
        check_word("restart_word", 0, 32'h0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
